// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display path.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 5;
    localparam int FRAME_W    = NUM_DIGITS * DIGIT_W;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HANDOVER
    } scan_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester found searching upward
// from last_owner+1, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    // last_owner itself is tried last, so a releasing client only wins again
    // when nobody else is asking.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!valid && req[j] && (j == (int'(last_owner) + k) % N_REQ)) begin
                    pick[j] = 1'b1;
                    valid   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Scans an 8-digit multiplexed display and shares it round-robin between
// display clients, handing over only on frame boundaries or owner release.
module seg_scan_arbiter
    import seg_pkg::*;
#(
    parameter int F_CLK       = 50000000,
    parameter int F_SCAN      = 1000,
    parameter int N_REQ       = 2,
    parameter int BLANK_CYC   = 5000,
    parameter int HOLD_FRAMES = 500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_W-1:0]   digits,
    output logic [N_REQ-1:0]           grant,
    output logic [2:0]                 cs_pointer,
    output logic [DIGIT_W-1:0]         dig_ctrl,
    output logic                       blank,
    output logic                       frame_done
);

    localparam int DIV   = F_CLK / F_SCAN;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FRM_W = $clog2(HOLD_FRAMES + 1);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [FRM_W-1:0] FRM_MAX = '1;
    localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

    scan_state_e       state, state_n;
    logic [CNT_W-1:0]  slot_cnt, slot_n;
    logic [FRM_W-1:0]  frame_cnt, frame_n;
    logic [IDX_W-1:0]  last_owner, last_n;
    logic [N_REQ-1:0]  grant_n;
    logic [2:0]        cs_n;
    digit_t            dig_n;
    logic              blank_n;
    logic              fd_n;

    logic [N_REQ-1:0]  pick;
    logic              pick_vld;
    logic [IDX_W-1:0]  owner_idx;
    logic [FRAME_W-1:0] cur_frame;
    digit_t            cur_digit;
    logic              owner_req;
    logic              other_req;
    logic              slot_end;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner),
        .pick       (pick),
        .valid      (pick_vld)
    );

    assign slot_end  = (slot_cnt == CNT_W'(DIV - 1));
    assign owner_req = |(req & grant);
    assign other_req = |(req & ~grant);

    // Live digit lookup: client edits show up on the next clock, no frame latch.
    always_comb begin
        owner_idx = '0;
        cur_frame = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                owner_idx = IDX_W'(i);
                cur_frame = digits[i*FRAME_W +: FRAME_W];
            end
        end
        cur_digit = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (cs_pointer == 3'(d)) begin
                cur_digit = cur_frame[d*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        slot_n  = slot_cnt;
        frame_n = frame_cnt;
        last_n  = last_owner;
        grant_n = grant;
        cs_n    = cs_pointer;
        fd_n    = 1'b0;

        case (state)
            IDLE: begin
                slot_n  = '0;
                cs_n    = '0;
                grant_n = '0;
                if (pick_vld) begin
                    grant_n = pick;
                    frame_n = '0;
                    state_n = SCAN;
                end
            end

            SCAN: begin
                slot_n = slot_end ? '0 : slot_cnt + 1'b1;
                if (slot_end) begin
                    // Owner release outranks the frame end, so no frame_done then.
                    if (!owner_req) begin
                        last_n  = owner_idx;
                        grant_n = '0;
                        cs_n    = '0;
                        frame_n = '0;
                        state_n = other_req ? HANDOVER : IDLE;
                    end else if (cs_pointer == LAST_DIGIT) begin
                        fd_n = 1'b1;
                        if (other_req && (int'(frame_cnt) + 1 >= HOLD_FRAMES)) begin
                            last_n  = owner_idx;
                            grant_n = '0;
                            cs_n    = '0;
                            frame_n = '0;
                            state_n = HANDOVER;
                        end else begin
                            if (frame_cnt != FRM_MAX) begin
                                frame_n = frame_cnt + 1'b1;
                            end
                            cs_n = '0;
                        end
                    end else begin
                        cs_n = cs_pointer + 1'b1;
                    end
                end
            end

            HANDOVER: begin
                slot_n  = slot_end ? '0 : slot_cnt + 1'b1;
                grant_n = '0;
                cs_n    = '0;
                if (slot_end) begin
                    if (pick_vld) begin
                        grant_n = pick;
                        frame_n = '0;
                        state_n = SCAN;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                slot_n  = '0;
                grant_n = '0;
                cs_n    = '0;
            end
        endcase

        blank_n = !((state_n == SCAN) && (int'(slot_n) >= BLANK_CYC));
        dig_n   = ((state == SCAN) && (state_n == SCAN)) ? cur_digit : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot_cnt   <= '0;
            frame_cnt  <= '0;
            last_owner <= IDX_W'(N_REQ - 1);
            grant      <= '0;
            cs_pointer <= '0;
            dig_ctrl   <= '0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            slot_cnt   <= slot_n;
            frame_cnt  <= frame_n;
            last_owner <= last_n;
            grant      <= grant_n;
            cs_pointer <= cs_n;
            dig_ctrl   <= dig_n;
            blank      <= blank_n;
            frame_done <= fd_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter with DIV=10, BLANK_CYC=2, HOLD_FRAMES=2.
module tb_seg_scan_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [79:0] digits;
    logic [1:0]  grant;
    logic [2:0]  cs_pointer;
    logic [4:0]  dig_ctrl;
    logic        blank;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_cnt = 0;

    // Client 0 shows 0..7, client 1 shows 0x17 down to 0x10 (dp set).
    localparam logic [39:0] C0 = {5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00};
    localparam logic [39:0] C1 = {5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};

    seg_scan_arbiter #(
        .F_CLK(1000), .F_SCAN(100), .N_REQ(2), .BLANK_CYC(2), .HOLD_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .digits     (digits),
        .grant      (grant),
        .cs_pointer (cs_pointer),
        .dig_ctrl   (dig_ctrl),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         scn;
        logic [1:0] rq;
        int         cyc;
        logic [1:0] grant;
        logic [2:0] cs;
        logic [4:0] dig;
        logic       blank;
        logic       fd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done) fd_cnt++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // Holds reset one cycle, checks reset outputs, releases; returns at cyc 0.
    task automatic do_reset(input logic [1:0] r);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = r;
        @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_cs", 32'(cs_pointer), 32'h0);
        chk("rst_dig", 32'(dig_ctrl), 32'h0);
        chk("rst_blank", 32'(blank), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        cyc = -1;
        step();
        fd_cnt = 0;
    endtask

    initial begin
        int bad;
        digits = {C1, C0};

        // Scenario 0: lone client 0.
        tbl.push_back('{0, 2'b01,   0, 2'b01, 3'd0, 5'h00, 1'b1, 1'b0});
        tbl.push_back('{0, 2'b01,   1, 2'b01, 3'd0, 5'h00, 1'b1, 1'b0});
        tbl.push_back('{0, 2'b01,   2, 2'b01, 3'd0, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{0, 2'b01,   9, 2'b01, 3'd0, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{0, 2'b01,  10, 2'b01, 3'd1, 5'h00, 1'b1, 1'b0});
        tbl.push_back('{0, 2'b01,  11, 2'b01, 3'd1, 5'h01, 1'b1, 1'b0});
        tbl.push_back('{0, 2'b01,  12, 2'b01, 3'd1, 5'h01, 1'b0, 1'b0});
        tbl.push_back('{0, 2'b01,  35, 2'b01, 3'd3, 5'h03, 1'b0, 1'b0});
        tbl.push_back('{0, 2'b01,  70, 2'b01, 3'd7, 5'h06, 1'b1, 1'b0});
        tbl.push_back('{0, 2'b01,  71, 2'b01, 3'd7, 5'h07, 1'b1, 1'b0});
        tbl.push_back('{0, 2'b01,  79, 2'b01, 3'd7, 5'h07, 1'b0, 1'b0});
        tbl.push_back('{0, 2'b01,  80, 2'b01, 3'd0, 5'h07, 1'b1, 1'b1});
        tbl.push_back('{0, 2'b01,  81, 2'b01, 3'd0, 5'h00, 1'b1, 1'b0});
        tbl.push_back('{0, 2'b01, 160, 2'b01, 3'd0, 5'h07, 1'b1, 1'b1});
        // Scenario 1: both clients request, two-frame hold and handover.
        tbl.push_back('{1, 2'b11,   0, 2'b01, 3'd0, 5'h00, 1'b1, 1'b0});
        tbl.push_back('{1, 2'b11,  80, 2'b01, 3'd0, 5'h07, 1'b1, 1'b1});
        tbl.push_back('{1, 2'b11, 159, 2'b01, 3'd7, 5'h07, 1'b0, 1'b0});
        tbl.push_back('{1, 2'b11, 160, 2'b00, 3'd0, 5'h00, 1'b1, 1'b1});
        tbl.push_back('{1, 2'b11, 165, 2'b00, 3'd0, 5'h00, 1'b1, 1'b0});
        tbl.push_back('{1, 2'b11, 169, 2'b00, 3'd0, 5'h00, 1'b1, 1'b0});
        tbl.push_back('{1, 2'b11, 170, 2'b10, 3'd0, 5'h00, 1'b1, 1'b0});
        tbl.push_back('{1, 2'b11, 171, 2'b10, 3'd0, 5'h17, 1'b1, 1'b0});
        tbl.push_back('{1, 2'b11, 172, 2'b10, 3'd0, 5'h17, 1'b0, 1'b0});
        tbl.push_back('{1, 2'b11, 250, 2'b10, 3'd0, 5'h10, 1'b1, 1'b1});
        tbl.push_back('{1, 2'b11, 330, 2'b00, 3'd0, 5'h00, 1'b1, 1'b1});
        tbl.push_back('{1, 2'b11, 340, 2'b01, 3'd0, 5'h00, 1'b1, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 0 || tbl[i].scn != tbl[i-1].scn) do_reset(tbl[i].rq);
            run_to(tbl[i].cyc);
            chk("tbl_grant", 32'(grant), 32'(tbl[i].grant));
            chk("tbl_cs", 32'(cs_pointer), 32'(tbl[i].cs));
            chk("tbl_dig", 32'(dig_ctrl), 32'(tbl[i].dig));
            chk("tbl_blank", 32'(blank), 32'(tbl[i].blank));
            chk("tbl_fd", 32'(frame_done), 32'(tbl[i].fd));
        end

        // Lone requester for 10 frames: never released, 10 frame pulses.
        do_reset(2'b01);
        bad = 0;
        while (cyc < 800) begin
            step();
            if (grant !== 2'b01) bad++;
        end
        chk("lone_grant_drops", 32'(bad), 32'h0);
        chk("lone_fd_count", 32'(fd_cnt), 32'd10);

        // Owner drops mid-frame at digit 3; live digit edit on the way.
        do_reset(2'b11);
        run_to(32);
        chk("drop_cs_before", 32'(cs_pointer), 32'd3);
        req = 2'b10;
        fd_cnt = 0;
        run_to(33);
        digits = {C1, C0[39:20], 5'h1A, C0[14:0]};
        run_to(34);
        chk("live_digit", 32'(dig_ctrl), 32'h1A);
        digits = {C1, C0};
        run_to(35);
        chk("drop_mid_slot_grant", 32'(grant), 32'h1);
        run_to(40);
        chk("drop_grant", 32'(grant), 32'h0);
        chk("drop_blank", 32'(blank), 32'h1);
        chk("drop_cs", 32'(cs_pointer), 32'h0);
        run_to(49);
        chk("drop_handover_grant", 32'(grant), 32'h0);
        run_to(50);
        chk("drop_new_grant", 32'(grant), 32'h2);
        chk("drop_new_cs", 32'(cs_pointer), 32'h0);
        chk("drop_no_fd", 32'(fd_cnt), 32'h0);

        // Owner drop on the frame-end slot with the other client waiting.
        do_reset(2'b11);
        run_to(75);
        req = 2'b10;
        fd_cnt = 0;
        run_to(80);
        chk("fe_drop_grant", 32'(grant), 32'h0);
        run_to(90);
        chk("fe_drop_new_grant", 32'(grant), 32'h2);
        chk("fe_drop_no_fd", 32'(fd_cnt), 32'h0);

        // Same coincidence with no other requester: goes idle.
        do_reset(2'b01);
        run_to(75);
        req = 2'b00;
        fd_cnt = 0;
        run_to(80);
        chk("fe_idle_grant", 32'(grant), 32'h0);
        run_to(90);
        chk("fe_idle_still", 32'(grant), 32'h0);
        chk("fe_idle_blank", 32'(blank), 32'h1);
        chk("fe_idle_no_fd", 32'(fd_cnt), 32'h0);
        req = 2'b10;
        step();
        chk("idle_regrant", 32'(grant), 32'h2);

        // Asynchronous reset mid-slot at digit 5.
        do_reset(2'b01);
        run_to(53);
        chk("ar_cs_before", 32'(cs_pointer), 32'd5);
        chk("ar_blank_before", 32'(blank), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_cs", 32'(cs_pointer), 32'h0);
        chk("ar_dig", 32'(dig_ctrl), 32'h0);
        chk("ar_blank", 32'(blank), 32'h1);
        chk("ar_fd", 32'(frame_done), 32'h0);
        @(posedge clk);
        #1;
        req = 2'b10;
        rst_n = 1'b1;
        cyc = -1;
        step();
        chk("ar_first_grant", 32'(grant), 32'h2);
        chk("ar_first_cs", 32'(cs_pointer), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_arbiter.md
Name: seg_scan_arbiter

Overview:
Shares the 8-digit multiplexed 7-segment display (chip-select pointer plus 5-bit digit code) between up to N_REQ display clients, such as the frequency readout and a counter readout.
Generates the digit-scan timing internally, with per-digit blanking against ghosting.
Grants the display round-robin, with frame-aligned handover.
Output feeds the existing chip-select decoder (cs_pointer) and segment decoder (dig_ctrl). This replaces free-running scan pointers in client modules.

Parameters:
F_CLK, 50000000, system clock frequency in Hz
F_SCAN, 1000, digit-slot rate in Hz; one slot is DIV = F_CLK/F_SCAN clocks
N_REQ, 2, number of display clients (2..4)
BLANK_CYC, 5000, clocks at the start of each slot with blank forced high; must be < DIV
HOLD_FRAMES, 500, full frames the owner keeps the display while another client is waiting (minimum 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-client display request, level-sensitive
digits  in  N_REQ*40  client i occupies bits [i*40 +: 40]; digit d is [d*5 +: 5]; bit4 = decimal point, bits3:0 = value; digit 0 is leftmost
grant  out  N_REQ  one-hot current owner; all zero when no client owns the display
cs_pointer  out  3  active digit index 0..7
dig_ctrl  out  5  digit code for the active digit
blank  out  1  high = all segments off
frame_done  out  1  one-clock pulse at the end of each completed 8-digit frame

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-low (rst_n). All outputs are registered.
- Reset values: grant=0, cs_pointer=0, dig_ctrl=0, blank=1, frame_done=0, state=IDLE, slot_cnt=0, frame_cnt=0, last_owner=N_REQ-1 (so client 0 wins first).
- slot_cnt counts 0..DIV-1 in SCAN and HANDOVER, and is held at 0 in IDLE.
- slot_end = (slot_cnt==DIV-1).
- States are IDLE, SCAN and HANDOVER.
- Round-robin pick: the first requesting index found by searching upward from last_owner+1, modulo N_REQ.
- IDLE:
  - blank=1, grant=0.
  - If any req bit is high, load grant with the pick next clock, set cs_pointer=0 and slot_cnt=0, and enter SCAN.
- SCAN:
  - blank=1 while slot_cnt < BLANK_CYC, else 0.
  - dig_ctrl is registered from digits[owner][cs_pointer] every clock, so it has 1-clock latency.
  - Digits are not latched per frame; client changes appear within 1 clock.
- On slot_end in SCAN, evaluate in this priority order:
  1. Owner req low: end ownership early.
     - last_owner=owner, grant=0, cs_pointer=0, frame_cnt=0.
     - frame_done is not pulsed.
     - Go to HANDOVER if another req is high, else IDLE.
  2. cs_pointer==7 (frame end):
     - Pulse frame_done.
     - If another client is requesting and frame_cnt+1 >= HOLD_FRAMES: last_owner=owner, grant=0, cs_pointer=0, frame_cnt=0, go to HANDOVER.
     - Otherwise frame_cnt++ (saturating), cs_pointer=0.
  3. Otherwise cs_pointer++.
- frame_cnt resets to 0 on every new grant.
- A lone requester keeps the display indefinitely.
- HANDOVER:
  - Lasts exactly one slot (DIV clocks), with blank=1, grant=0 and dig_ctrl=0.
  - On its slot_end, re-run the pick. If a client wins, grant it next clock with cs_pointer=0 and enter SCAN; otherwise go to IDLE.
  - Handover never grants the client that just released unless it is the only requester.
- Simultaneous events:
  - Owner drop coinciding with frame end: rule 1 wins, with no frame_done.
  - Req changes from non-owners mid-slot are sampled only at slot_end.
- grant is always one-hot or zero, and changes only at slot_end or on leaving IDLE.
- Reset mid-operation returns all outputs to their reset values immediately (asynchronous), with no partial frame_done.

Decomposition:
- Shared package seg_pkg holds:
  - NUM_DIGITS=8
  - DIGIT_W=5
  - FRAME_W=NUM_DIGITS*DIGIT_W
  - typedef digit_t (logic [DIGIT_W-1:0])
  - enum scan_state_e {IDLE, SCAN, HANDOVER}
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, last_owner.
  - Outputs: one-hot pick and a valid flag.

Test Plan:
- Bench parameters for all scenarios: F_CLK=1000, F_SCAN=100 (DIV=10), BLANK_CYC=2, HOLD_FRAMES=2, N_REQ=2.
- Reset, then req=01, client0 digits = 0..7 -> grant=01 the clock after req rises. cs_pointer steps 0..7 every 10 clocks. blank is high for 2 clocks of each slot. dig_ctrl = pointer value, 1 clock after the pointer changes. frame_done pulses every 80 clocks.
- req=11 from reset -> client0 holds for 2 frames (160 clocks). Then a 10-clock HANDOVER with blank=1 and grant=00. Then grant=10 for 2 frames, then back to 01.
- Client0 owner, drop req0 at cs_pointer=3 with req1 high -> at that slot_end grant=00 and no frame_done. After 10 clocks grant=10 with cs_pointer=0.
- req=01 only, for 10 frames -> grant stays 01, frame_done pulses 10 times, and no HANDOVER occurs.
- Assert rst_n low mid-slot at cs_pointer=5 -> same-cycle outputs: grant=0, cs_pointer=0, dig_ctrl=0, blank=1, frame_done=0. After release with req=10, client1 is granted first, since last_owner reset is 1 and the search starts at 0 but only req1 is high.
- Owner drop coinciding with cs_pointer=7 slot_end -> no frame_done pulse; state goes to HANDOVER if the other client requests, else IDLE.
